// File: rtl/uart_pkg.sv
// Shared UART framing definitions used by both the transmit and receive paths.
package uart_pkg;

  // Frame-level FSM encoding, common to the receive and transmit sides.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Small synchronous FIFO for response bytes. Pointers carry an extra MSB so
// that full and empty can be told apart when the indices are equal.
module resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is still taken when the head leaves this cycle.
  assign push_ok = push && (!full || pop_ok);
  // Head is read combinationally so the consumer can load it in the pop cycle.
  assign dout    = mem[rd_ptr_reg[AW-1:0]];
  assign level   = level_reg;

  // Storage write; contents are not reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_resp_tx.sv
// Response return path: buffers {address, data} bytes from the register bus
// and serialises them as UART frames (start, 8 data LSB first, optional even
// parity, stop).
module uart_resp_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    address,
  input  logic [3:0]                    data_out,
  input  logic                          data_out_valid,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  uart_state_t   state_reg;
  uart_state_t   state_next;
  logic [CW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic          tx_reg;
  logic          tx_next;
  logic          overflow_reg;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic          pop;
  logic          drop;
  logic          baud_done;
  logic          data_last;
  logic          stop_last;

  assign pop       = (state_reg == IDLE) && !fifo_empty;
  assign drop      = data_out_valid && fifo_full && !pop;
  assign baud_done = (baud_cnt_reg == CW'(DIV - 1));
  assign data_last = (bit_cnt_reg == 3'(DATA_BITS - 1));
  assign stop_last = (bit_cnt_reg == 3'(STOP_BITS - 1));

  resp_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_out_valid),
    .din   ({address, data_out}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state: each line state lasts DIV cycles; IDLE leaves as soon as a byte waits.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (!fifo_empty) state_next = START;
      START:  if (baud_done) state_next = DATA;
      DATA:   if (baud_done && data_last)
                state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (baud_done) state_next = STOP;
      STOP:   if (baud_done && stop_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Line level for the current state; registered below so tx is glitch-free.
  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      PARITY:  tx_next = parity_reg;
      default: tx_next = 1'b1;
    endcase
  end

  // Registered tx; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_reg <= 1'b1;
    else      tx_reg <= tx_next;
  end

  // Baud/bit counters, shift register and parity capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
    end else if (state_reg == IDLE) begin
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      if (pop) begin
        shift_reg  <= fifo_dout;
        parity_reg <= even_parity(fifo_dout);
      end
    end else if (baud_done) begin
      baud_cnt_reg <= '0;
      if (state_reg == DATA) begin
        shift_reg   <= shift_reg >> 1;
        bit_cnt_reg <= data_last ? 3'd0 : bit_cnt_reg + 3'd1;
      end else if (state_reg == STOP) begin
        bit_cnt_reg <= stop_last ? 3'd0 : bit_cnt_reg + 3'd1;
      end
    end else begin
      baud_cnt_reg <= baud_cnt_reg + 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow_reg <= 1'b0;
    else if (drop)    overflow_reg <= 1'b1;
    else if (ovf_clr) overflow_reg <= 1'b0;
  end

  assign tx       = tx_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_resp_tx.sv
// Directed bench for uart_resp_tx with DIV=4; a second instance runs without parity.
module tb_uart_resp_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] address = '0, data_out = '0;
  logic       data_out_valid = 1'b0, ovf_clr = 1'b0;
  logic       tx, busy, overflow;
  logic [3:0] fifo_level;

  logic [3:0] np_address = '0, np_data = '0;
  logic       np_valid = 1'b0, np_ovf_clr = 1'b0;
  logic       np_tx, np_busy, np_overflow;
  logic [3:0] np_level;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_resp_tx #(.CLK_HZ(40), .BAUD(10), .PARITY_EN(1), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .address(address), .data_out(data_out),
    .data_out_valid(data_out_valid), .ovf_clr(ovf_clr), .tx(tx), .busy(busy),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  uart_resp_tx #(.CLK_HZ(40), .BAUD(10), .PARITY_EN(0), .FIFO_DEPTH(8)) dut_np (
    .clk(clk), .rst(rst), .address(np_address), .data_out(np_data),
    .data_out_valid(np_valid), .ovf_clr(np_ovf_clr), .tx(np_tx), .busy(np_busy),
    .overflow(np_overflow), .fifo_level(np_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    address = b[7:4];
    data_out = b[3:0];
    data_out_valid = 1'b1;
    tick();
    data_out_valid = 1'b0;
  endtask

  // Receive one frame by mid-bit sampling; polling starts before the start bit.
  task automatic rx_frame(input bit np, output logic [7:0] b, output logic p,
                          output logic s, output int t0);
    int n;
    n = 0;
    b = '0; p = 1'b0; s = 1'b0; t0 = -1;
    while (((np ? np_tx : tx) !== 1'b0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout: got no start bit within %0d cycles, required one", n);
      return;
    end
    t0 = cyc;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      repeat (4) tick();
      b[i] = np ? np_tx : tx;
    end
    if (!np) begin
      repeat (4) tick();
      p = tx;
    end
    repeat (4) tick();
    s = np ? np_tx : tx;
    $display("frame start=%0d byte=%02h parity=%b stop=%b", t0, b, p, s);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (np_tx !== 1'b1) begin errors++; $display("FAIL reset_np_tx: got %b want 1", np_tx); end
    rst = 1'b1;
    repeat (2) tick();
    $display("reset done");
  endtask

  task automatic test_single();
    logic exp_bits [11];
    logic [7:0] b;
    b = 8'hA3;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    exp_bits[9] = 1'b0;
    exp_bits[10] = 1'b1;
    strobe(b);
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL single_level0: got %0d want 1", fifo_level); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy0: got %b want 1", busy); end
    tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_latency1: got %b want 1", tx); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_level1: got %0d want 0", fifo_level); end
    for (int k = 0; k < 44; k++) begin
      tick();
      checks++;
      if (tx !== exp_bits[k/4]) begin
        errors++;
        $display("FAIL single_bit cycle %0d: got %b want %b", k, tx, exp_bits[k/4]);
      end
      if (k == 42) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %b want 1", busy); end
      end
      if (k == 43) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy); end
      end
    end
    tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", tx); end
    $display("single frame 0xA3 done");
  endtask

  task automatic test_no_parity();
    logic exp_bits [10];
    logic [7:0] b;
    b = 8'h07;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    exp_bits[9] = 1'b1;
    np_address = b[7:4];
    np_data = b[3:0];
    np_valid = 1'b1;
    tick();
    np_valid = 1'b0;
    tick();
    checks++; if (np_tx !== 1'b1) begin errors++; $display("FAIL np_latency1: got %b want 1", np_tx); end
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (np_tx !== exp_bits[k/4]) begin
        errors++;
        $display("FAIL np_bit cycle %0d: got %b want %b", k, np_tx, exp_bits[k/4]);
      end
      if (k == 38) begin
        checks++; if (np_busy !== 1'b1) begin errors++; $display("FAIL np_busy_hold: got %b want 1", np_busy); end
      end
      if (k == 39) begin
        checks++; if (np_busy !== 1'b0) begin errors++; $display("FAIL np_busy_drop: got %b want 0", np_busy); end
      end
    end
    tick();
    checks++; if (np_tx !== 1'b1) begin errors++; $display("FAIL np_idle: got %b want 1", np_tx); end
    $display("no-parity frame 0x07 done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    logic [7:0] b;
    logic p, s;
    int t0, t_prev, peak;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      address = exp_b[i][7:4];
      data_out = exp_b[i][3:0];
      data_out_valid = 1'b1;
      tick();
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    data_out_valid = 1'b0;
    checks++; if (peak != 2) begin errors++; $display("FAIL burst_peak: got %0d want 2", peak); end
    t_prev = 0;
    for (int f = 0; f < 3; f++) begin
      rx_frame(1'b0, b, p, s, t0);
      checks++; if (b !== exp_b[f]) begin errors++; $display("FAIL burst_byte%0d: got %02h want %02h", f, b, exp_b[f]); end
      checks++; if (p !== ^exp_b[f]) begin errors++; $display("FAIL burst_par%0d: got %b want %b", f, p, ^exp_b[f]); end
      if (f > 0) begin
        checks++; if (t0 - t_prev != 45) begin errors++; $display("FAIL burst_gap%0d: got %0d want 45", f, t0 - t_prev); end
      end
      t_prev = t0;
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] rb [9];
    logic       rp [9];
    logic       rs [9];
    int         rt [9];
    logic [7:0] e;
    repeat (4) tick();
    fork
      begin
        for (int f = 0; f < 9; f++) rx_frame(1'b0, rb[f], rp[f], rs[f], rt[f]);
      end
      begin
        for (int i = 0; i < 10; i++) strobe({4'(i), 4'(15 - i)});
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end
      end
    join
    for (int f = 0; f < 9; f++) begin
      e = {4'(f), 4'(15 - f)};
      checks++; if (rb[f] !== e) begin errors++; $display("FAIL ovf_byte%0d: got %02h want %02h", f, rb[f], e); end
      checks++; if (rp[f] !== ^e || rs[f] !== 1'b1) begin
        errors++; $display("FAIL ovf_frame%0d: got par=%b stop=%b want par=%b stop=1", f, rp[f], rs[f], ^e);
      end
    end
    repeat (4) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_push_full_pop();
    logic [7:0] b, e;
    logic p, s;
    int t0;
    repeat (4) tick();
    for (int i = 0; i < 9; i++) strobe({4'hC, 4'(i)});
    repeat (37) tick();
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fullpop_pre_level: got %0d want 8", fifo_level); end
    strobe(8'hE7);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fullpop_level: got %0d want 8", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    for (int f = 1; f <= 9; f++) begin
      rx_frame(1'b0, b, p, s, t0);
      e = (f == 9) ? 8'hE7 : {4'hC, 4'(f)};
      checks++; if (b !== e) begin errors++; $display("FAIL fullpop_byte%0d: got %02h want %02h", f, b, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic p, s;
    int t0, ts;
    repeat (4) tick();
    strobe(8'h5C);
    strobe(8'h6D);
    repeat (18) tick();
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL rstmid_pre_level: got %0d want 1", fifo_level); end
    rst = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    tick();
    rst = 1'b1;
    tick();
    strobe(8'h96);
    ts = cyc;
    rx_frame(1'b0, b, p, s, t0);
    checks++; if (t0 - ts != 2) begin errors++; $display("FAIL rstmid_latency: got %0d want 2", t0 - ts); end
    checks++; if (b !== 8'h96) begin errors++; $display("FAIL rstmid_byte: got %02h want 96", b); end
    checks++; if (p !== 1'b0 || s !== 1'b1) begin errors++; $display("FAIL rstmid_frame: got par=%b stop=%b want par=0 stop=1", p, s); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_no_parity();
    test_back_to_back();
    test_overflow();
    test_push_full_pop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_resp_tx.md
Name: uart_resp_tx

Overview:
- Return path of the host link: captures register read-back responses (data_out/data_out_valid from the OR-merged register bus) and serializes them onto a UART Tx line.
- Sits downstream of the clock/UART/channel register responders and mirrors the receive framing: start bit, 8 data bits LSB first, optional even parity, stop bit.
- Each response byte is {address[3:0], data_out[3:0]}, buffered in a small FIFO so bursts of back-to-back responses are not lost.

Parameters:
CLK_HZ, 100000000, system clock frequency
BAUD, 9600, line rate; bit period DIV = CLK_HZ/BAUD cycles (integer, ≥2)
PARITY_EN, 1, 1 = even parity bit between data and stop; 0 = no parity bit
FIFO_DEPTH, 8, response FIFO entries (power of two, ≥2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
address  in  4  register address of the response, sampled with data_out_valid
data_out  in  4  response data
data_out_valid  in  1  one-cycle strobe; push {address,data_out}
ovf_clr  in  1  clears sticky overflow
tx  out  1  serial line, idle high
busy  out  1  high while a frame is on the line or FIFO non-empty
overflow  out  1  sticky: a push was dropped
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst low, async): tx=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, baud counter=0, FIFO pointers=0. Reset mid-frame aborts immediately; tx returns high in the same cycle; FIFO contents discarded.
- Push: on a rising edge with data_out_valid=1, write {address,data_out}. If full and no pop in the same cycle → drop, set overflow. If full and pop in the same cycle → push accepted, level unchanged. Simultaneous push/pop when not full → level unchanged.
- overflow: cleared by ovf_clr=1. If ovf_clr and a dropped push occur in the same cycle, overflow is set (set wins).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if FIFO non-empty, pop into an 8-bit shift register, compute even parity (XOR of 8 bits), clear the baud counter, go to START. tx=1 while in IDLE.
- Each non-IDLE state holds its bit for exactly DIV cycles. The baud counter runs 0..DIV-1; the state advances on DIV-1.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right after each bit; 8 bits, bit counter 0..7.
  - PARITY: only when PARITY_EN=1; tx=parity.
  - STOP: tx=1.
- After STOP: go back to IDLE. IDLE pops the next entry on its first cycle, so there is 1 idle cycle (tx high) between frames.
- Latency: tx falls on the 2nd rising edge after the edge that samples data_out_valid with FIFO empty and FSM idle.
- Frame length: (10 + PARITY_EN)·DIV cycles, counted from the tx falling edge to the end of the stop bit.
- busy = (FSM≠IDLE) | (fifo_level≠0). All outputs are registered except busy, which is combinational from registers.
- Read-pointer and write-pointer wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer MSB.

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE..STOP) and the frame bit-count constants DATA_BITS=8 and STOP_BITS=1. The receive side uses the same package.
- One sub-module resp_fifo: synchronous FIFO, parameters WIDTH=8 and DEPTH.
  - Ports: clk, rst, push, din, pop, dout, full, empty, level.
  - Same-cycle push-on-full-with-pop rule as above.
- The top FSM, baud counter and parity logic stay in uart_resp_tx.

Test Plan:
- Bench parameters: DIV=4 (CLK_HZ=40, BAUD=10), PARITY_EN=1.
- Single response: address=4'hA, data_out=4'h3 → tx falls 2 cycles after the strobe. Line bits each last 4 cycles: 0, then 1,1,0,0,0,1,0,1 (0xA3 LSB first), parity 0, stop 1. busy drops after 44 cycles.
- PARITY_EN=0, byte 0x07 → 10-bit frame: 0, 1,1,1,0,0,0,0,0, 1. Frame lasts 40 cycles; no parity slot.
- Burst of 3 strobes on consecutive cycles (0x11, 0x22, 0x33) → three frames in order, 1 idle cycle between them. fifo_level peaks at 2, overflow stays 0.
- Overflow: FIFO_DEPTH=8, hold tx mid-frame and push 10 responses → fifo_level=8 with the first popped, 1 dropped, overflow=1. ovf_clr → overflow=0. The 9 accepted bytes are transmitted intact.
- Push on full with simultaneous pop (pop cycle in IDLE) → accepted, level stays 8, overflow unchanged.
- Assert rst low mid DATA bit 3 → tx=1 immediately, fifo_level=0, busy=0. After release, a new strobe produces a clean frame.
